// File: rtl/rom_loader_receiver_if.sv
// Loader handshake (load/sck/data/ack) and ROM SRAM controller write port.
// master: external loader plus controller side; slave: rom_loader_receiver.
interface rom_loader_receiver_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  rom_loader_load;
  logic                  rom_loader_sck;
  logic [DATA_WIDTH-1:0] rom_loader_data;
  logic                  rom_loader_ack;
  logic                  mem_write_req;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_write_done;

  modport master (
    output rom_loader_load, rom_loader_sck, rom_loader_data, mem_write_done,
    input  rom_loader_ack, mem_write_req, mem_address, mem_data
  );

  modport slave (
    input  rom_loader_load, rom_loader_sck, rom_loader_data, mem_write_done,
    output rom_loader_ack, mem_write_req, mem_address, mem_data
  );
endinterface

// File: rtl/rom_loader_receiver.sv
// SoC-side receiver of the ROM-loading link. Stores each handshaked word
// into the ROM through the SRAM controller write port at sequential
// addresses from 0, and holds the CPU in reset (loading) during a session.
// Optional: define ROM_LOADER_CHECKSUM_EN to add a running 16-bit sum
// output (checksum) of all words written in the current/last session.
//
// state    | meaning
// IDLE     | no session; waiting for load
// WAIT_SCK | session active; waiting for the next sck rising edge
// WRITE    | write request outstanding to the SRAM controller
// ACK      | ack asserted; waiting for sck to go low
module rom_loader_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic                  clk,
  input  logic                  reset,
  rom_loader_receiver_if.slave  bus,
  output logic                  loading,
  output logic [ADDR_WIDTH-1:0] words_loaded
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_SCK, WRITE, ACK} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] load_sr, sck_sr;
  logic                   sck_prev;
  logic                   load_sync, sck_sync, sck_rise;

  logic                  ack_q, ack_n;
  logic                  req_q, req_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  loading_q, loading_n;
  logic [ADDR_WIDTH-1:0] wl_q, wl_n;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cks_q, cks_n;
`endif

  assign load_sync = load_sr[SYNC_STAGES-1];
  assign sck_sync  = sck_sr[SYNC_STAGES-1];
  assign sck_rise  = sck_sync & ~sck_prev;

  // Synchronize the asynchronous loader strobes; data is sampled only once
  // sck has been seen stable high, so it needs no synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_sr  <= '0;
      sck_sr   <= '0;
      sck_prev <= 1'b0;
    end else begin
      load_sr  <= {load_sr[SYNC_STAGES-2:0], bus.rom_loader_load};
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], bus.rom_loader_sck};
      sck_prev <= sck_sync;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; an sck rise outside WAIT_SCK never starts a write.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (load_sync) state_n = WAIT_SCK;
      WAIT_SCK: begin
        if (sck_rise)        state_n = WRITE;
        else if (!load_sync) state_n = IDLE;
      end
      WRITE:    if (bus.mem_write_done) state_n = ACK;
      ACK:      if (!sck_sync) state_n = WAIT_SCK;
      default:  state_n = IDLE;
    endcase
  end

  // Output/datapath next values, registered below.
  always_comb begin
    ack_n     = ack_q;
    req_n     = req_q;
    addr_n    = addr_q;
    data_n    = data_q;
    loading_n = loading_q;
    wl_n      = wl_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    cks_n     = cks_q;
`endif
    case (state)
      IDLE: begin
        if (load_sync) begin
          loading_n = 1'b1;
          addr_n    = '0;
          wl_n      = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
          cks_n     = '0;
`endif
        end
      end
      WAIT_SCK: begin
        if (sck_rise) begin
          data_n = bus.rom_loader_data;
          req_n  = 1'b1;
        end else if (!load_sync) begin
          loading_n = 1'b0;
        end
      end
      WRITE: begin
        if (bus.mem_write_done) begin
          req_n = 1'b0;
          ack_n = 1'b1;
          // Count saturates so a full-size ROM load still reads sensibly.
          if (wl_q != '1) wl_n = wl_q + ADDR_ONE;
`ifdef ROM_LOADER_CHECKSUM_EN
          cks_n = cks_q + data_q;
`endif
        end
      end
      ACK: begin
        if (!sck_sync) begin
          ack_n  = 1'b0;
          addr_n = addr_q + ADDR_ONE;
        end
      end
      default: ;
    endcase
  end

  // Output registers; reset abandons any outstanding write request.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q     <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      loading_q <= 1'b0;
      wl_q      <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      cks_q     <= '0;
`endif
    end else begin
      ack_q     <= ack_n;
      req_q     <= req_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
      loading_q <= loading_n;
      wl_q      <= wl_n;
`ifdef ROM_LOADER_CHECKSUM_EN
      cks_q     <= cks_n;
`endif
    end
  end

  assign bus.rom_loader_ack = ack_q;
  assign bus.mem_write_req  = req_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_data       = data_q;
  assign loading            = loading_q;
  assign words_loaded       = wl_q;
`ifdef ROM_LOADER_CHECKSUM_EN
  assign checksum           = cks_q;
`endif

endmodule

// File: tb/tb_rom_loader_receiver.sv
// Bench for rom_loader_receiver: a 16-bit-address instance and a 4-bit-address
// instance share the loader stimulus, each with its own write responder.
module tb_rom_loader_receiver;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic sck = 1'b0;
  logic [15:0] data = '0;
  logic done16 = 1'b0;
  logic done4 = 1'b0;
  logic loading16, loading4;
  logic [15:0] wl16;
  logic [3:0]  wl4;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] cks16, cks4;
`endif

  always #5 clk = ~clk;

  rom_loader_receiver_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus16 ();
  rom_loader_receiver_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4))  bus4 ();

  assign bus16.rom_loader_load = load;
  assign bus16.rom_loader_sck  = sck;
  assign bus16.rom_loader_data = data;
  assign bus16.mem_write_done  = done16;
  assign bus4.rom_loader_load  = load;
  assign bus4.rom_loader_sck   = sck;
  assign bus4.rom_loader_data  = data;
  assign bus4.mem_write_done   = done4;

  rom_loader_receiver #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus16.slave),
    .loading(loading16), .words_loaded(wl16)
`ifdef ROM_LOADER_CHECKSUM_EN
    , .checksum(cks16)
`endif
  );

  rom_loader_receiver #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave),
    .loading(loading4), .words_loaded(wl4)
`ifdef ROM_LOADER_CHECKSUM_EN
    , .checksum(cks4)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  wr_t q16[$];
  wr_t q4[$];
  logic [15:0] words[$];

  int done_delay = 2;
  bit pend16 = 0, pend4 = 0;
  int cnt16 = 0, cnt4 = 0;
  int nreq16 = 0, nreq4 = 0;
  logic req16_prev = 1'b0, req4_prev = 1'b0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Controller model: pulses write_done done_delay cycles after a request and
  // logs the (address, data) of each completed write.
  always @(negedge clk) begin
    if (done16) done16 = 1'b0;
    else if (pend16) begin
      if (cnt16 == 0) begin
        done16 = 1'b1;
        pend16 = 0;
        if (bus16.mem_write_req) q16.push_back('{bus16.mem_address, bus16.mem_data});
      end else cnt16--;
    end else if (bus16.mem_write_req) begin
      pend16 = 1;
      cnt16  = done_delay;
    end
    if (bus16.mem_write_req && !req16_prev) nreq16++;
    req16_prev = bus16.mem_write_req;
  end

  always @(negedge clk) begin
    if (done4) done4 = 1'b0;
    else if (pend4) begin
      if (cnt4 == 0) begin
        done4 = 1'b1;
        pend4 = 0;
        if (bus4.mem_write_req) q4.push_back('{16'(bus4.mem_address), bus4.mem_data});
      end else cnt4--;
    end else if (bus4.mem_write_req) begin
      pend4 = 1;
      cnt4  = done_delay;
    end
    if (bus4.mem_write_req && !req4_prev) nreq4++;
    req4_prev = bus4.mem_write_req;
  end

  localparam int P_LOADING = 0, P_ACK = 1, P_REQ = 2;

  function automatic logic probe(input int which);
    case (which)
      P_LOADING: return loading16;
      P_ACK:     return bus16.rom_loader_ack;
      default:   return bus16.mem_write_req;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input string nm);
    for (int i = 0; i < 300; i++) begin
      if (probe(which) === val) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL timeout %s: still 0x%0h expected 0x%0h", nm, probe(which), val);
  endtask

  task automatic send_word(input logic [15:0] w, input int hold, input bit drop);
    @(negedge clk);
    data = w;
    sck  = 1'b1;
    if (drop) begin
      wait_for(P_REQ, 1'b1, "req_rise");
      load = 1'b0;
    end
    wait_for(P_ACK, 1'b1, "ack_rise");
    repeat (hold) @(negedge clk);
    if (hold > 0) check("ack_held_while_sck_high", bus16.rom_loader_ack, 1);
    sck = 1'b0;
    wait_for(P_ACK, 1'b0, "ack_fall");
  endtask

  // Sends words[] as one session and checks against the reference rules:
  // word i lands at address i mod 2^AW, count = min(n, 2^AW-1), sum mod 2^16.
  task automatic run_session(input int hold, input bit drop, input int exp16, input int exp4);
    int n;
    logic [15:0] sum;
    n = words.size();
    q16.delete();
    q4.delete();
    nreq16 = 0;
    nreq4  = 0;
    @(negedge clk);
    load = 1'b1;
    wait_for(P_LOADING, 1'b1, "loading_rise");
    check("session_start_words_loaded", wl16, 0);
    check("session_start_address", bus16.mem_address, 0);
    for (int i = 0; i < n; i++) send_word(words[i], hold, drop && (i == n - 1));
    load = 1'b0;
    wait_for(P_LOADING, 1'b0, "loading_fall");
    repeat (3) @(negedge clk);
    check("loading_after_session", loading16, 0);
    check("writes16_count", q16.size(), n);
    check("writes4_count", q4.size(), n);
    check("req16_count", nreq16, n);
    check("req4_count", nreq4, n);
    sum = '0;
    for (int i = 0; i < n; i++) begin
      sum = sum + words[i];
      if (i < q16.size()) begin
        check($sformatf("w16[%0d].addr", i), q16[i].addr, i % 65536);
        check($sformatf("w16[%0d].data", i), q16[i].data, words[i]);
      end
      if (i < q4.size()) begin
        check($sformatf("w4[%0d].addr", i), q4[i].addr, i % 16);
        check($sformatf("w4[%0d].data", i), q4[i].data, words[i]);
      end
    end
    check("words_loaded16", wl16, exp16);
    check("words_loaded4", wl4, exp4);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("checksum16", cks16, sum);
    check("checksum4", cks4, sum);
`endif
  endtask

  typedef struct {
    int n; int delay; int hold; bit drop; bit use_fixed; int exp_wl16; int exp_wl4;
  } vec_t;

  vec_t tbl[5];
  logic [15:0] fixed_words[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    fixed_words[0] = 16'h1234;
    fixed_words[1] = 16'hABCD;
    fixed_words[2] = 16'h0000;
    tbl[0] = '{n: 3,  delay: 4,  hold: 0,  drop: 0, use_fixed: 1, exp_wl16: 3,  exp_wl4: 3};
    tbl[1] = '{n: 1,  delay: 20, hold: 50, drop: 0, use_fixed: 0, exp_wl16: 1,  exp_wl4: 1};
    tbl[2] = '{n: 6,  delay: 2,  hold: 1,  drop: 1, use_fixed: 0, exp_wl16: 6,  exp_wl4: 6};
    tbl[3] = '{n: 18, delay: 0,  hold: 0,  drop: 0, use_fixed: 0, exp_wl16: 18, exp_wl4: 15};
    tbl[4] = '{n: 5,  delay: 3,  hold: 2,  drop: 0, use_fixed: 0, exp_wl16: 5,  exp_wl4: 5};

    // Reset with load and sck high: everything stays cleared.
    reset = 1'b1;
    load  = 1'b1;
    sck   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", bus16.rom_loader_ack, 0);
    check("rst_req", bus16.mem_write_req, 0);
    check("rst_addr", bus16.mem_address, 0);
    check("rst_data", bus16.mem_data, 0);
    check("rst_loading", loading16, 0);
    check("rst_words_loaded", wl16, 0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("loading_before_sync", loading16, 0);
    @(negedge clk);
    check("loading_after_sync", loading16, 1);
    repeat (5) @(negedge clk);
    check("held_sck_no_write", bus16.mem_write_req, 0);
    load = 1'b0;
    sck  = 1'b0;
    wait_for(P_LOADING, 1'b0, "reset_test_loading_fall");

    foreach (tbl[k]) begin
      done_delay = tbl[k].delay;
      words.delete();
      for (int i = 0; i < tbl[k].n; i++)
        words.push_back(tbl[k].use_fixed ? fixed_words[i] : 16'($urandom));
      run_session(tbl[k].hold, tbl[k].drop, tbl[k].exp_wl16, tbl[k].exp_wl4);
    end

    // Reset while a write is outstanding drops the request at once.
    done_delay = 30;
    @(negedge clk);
    load = 1'b1;
    wait_for(P_LOADING, 1'b1, "midwrite_loading_rise");
    data = 16'h5A5A;
    sck  = 1'b1;
    wait_for(P_REQ, 1'b1, "midwrite_req_rise");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midwrite_req_dropped", bus16.mem_write_req, 0);
    check("midwrite_loading", loading16, 0);
    check("midwrite_words_loaded", wl16, 0);
    reset = 1'b0;
    load  = 1'b0;
    sck   = 1'b0;
    repeat (40) @(negedge clk);

    // Checksum wrap, then a following session restarts the sum from zero.
    done_delay = 1;
    words.delete();
    words.push_back(16'hFFFF);
    words.push_back(16'h0002);
    run_session(0, 0, 2, 2);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("checksum_wrap", cks16, 16'h0001);
`endif
    words.delete();
    words.push_back(16'h0005);
    run_session(0, 0, 1, 1);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("checksum_second_session", cks16, 16'h0005);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
